// File: rtl/segment_scan_if.sv
// Bus between a multiplexed seven-segment display driver and the scan decoder.
// The master drives the segment and anode lines, and the slave returns the recovered frame.
interface segment_scan_if #(
    parameter int NUM_DIGITS = 6
);
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   an_in;
    logic [4*NUM_DIGITS-1:0] digits_out;
    logic [NUM_DIGITS-1:0]   digit_err;
    logic                    frame_valid;

    modport master (
        output seg_in, an_in,
        input  digits_out, digit_err, frame_valid
    );

    modport slave (
        input  seg_in, an_in,
        output digits_out, digit_err, frame_valid
    );
endinterface

// File: rtl/segment_scan_decoder.sv
// Recovers BCD digits from an active-low multiplexed seven-segment bus.
// A frame is presented after every digit position has been seen with a stable pattern.
module segment_scan_decoder #(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input logic           clk,
    input logic           rst,
    segment_scan_if.slave bus
);
    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t state, state_next;
    logic [7:0]                cnt, cnt_next;
    logic [NUM_DIGITS+6:0]     pair, pair_prev;
    logic [NUM_DIGITS-1:0]     slot_mask;
    logic                      slot_ok;
    logic                      same;
    logic                      accept;
    logic [4:0]                decoded;
    logic [4*NUM_DIGITS-1:0]   shadow, digits_q;
    logic [NUM_DIGITS-1:0]     shadow_err, err_q;
    logic [NUM_DIGITS-1:0]     seen;
    logic                      frame_pend;
    logic                      fv_q;

    // Returns {invalid, digit}; anything that is not a decimal glyph decodes to 4'hF.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: seg_decode = 5'h00;
            7'b1111001: seg_decode = 5'h01;
            7'b0100100: seg_decode = 5'h02;
            7'b0110000: seg_decode = 5'h03;
            7'b0011001: seg_decode = 5'h04;
            7'b0010010: seg_decode = 5'h05;
            7'b0000010: seg_decode = 5'h06;
            7'b1111000: seg_decode = 5'h07;
            7'b0000000: seg_decode = 5'h08;
            7'b0010000: seg_decode = 5'h09;
            default:    seg_decode = 5'h1F;
        endcase
    endfunction

    assign pair      = {bus.an_in, bus.seg_in};
    assign slot_mask = ~bus.an_in;
    assign slot_ok   = $onehot(slot_mask);
    assign same      = (pair == pair_prev);
    assign decoded   = seg_decode(bus.seg_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            pair_prev <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            pair_prev <= pair;
        end
    end

    // A changed or fresh sample restarts the count at 1 when it is a slot, otherwise the FSM drops to IDLE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            SETTLE: begin
                if (same) begin
                    if (cnt + 8'd1 >= STABLE_LIM) begin
                        accept     = 1'b1;
                        cnt_next   = STABLE_LIM;
                        state_next = HOLD;
                    end else begin
                        cnt_next = cnt + 8'd1;
                    end
                end else if (slot_ok) begin
                    cnt_next   = 8'd1;
                    state_next = SETTLE;
                end else begin
                    cnt_next   = 8'd0;
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (!same) begin
                    if (slot_ok) begin
                        cnt_next   = 8'd1;
                        state_next = SETTLE;
                    end else begin
                        cnt_next   = 8'd0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                if (slot_ok) begin
                    cnt_next   = 8'd1;
                    state_next = SETTLE;
                end else begin
                    cnt_next   = 8'd0;
                    state_next = IDLE;
                end
            end
        endcase
    end

    // The frame is published one edge after the last acceptance so that it includes that digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow     <= '0;
            shadow_err <= '0;
            seen       <= '0;
            frame_pend <= 1'b0;
            digits_q   <= '0;
            err_q      <= '0;
            fv_q       <= 1'b0;
        end else begin
            fv_q       <= frame_pend;
            frame_pend <= 1'b0;
            if (frame_pend) begin
                digits_q <= shadow;
                err_q    <= shadow_err;
            end
            if (accept) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (slot_mask[i]) begin
                        shadow[4*i +: 4] <= decoded[3:0];
                        shadow_err[i]    <= decoded[4];
                    end
                end
                if ((seen | slot_mask) == {NUM_DIGITS{1'b1}}) begin
                    seen       <= '0;
                    frame_pend <= 1'b1;
                end else begin
                    seen <= seen | slot_mask;
                end
            end
        end
    end

    assign bus.digits_out  = digits_q;
    assign bus.digit_err   = err_q;
    assign bus.frame_valid = fv_q;
endmodule

// File: tb/tb_segment_scan_decoder.sv
// Directed bench for segment_scan_decoder: 6 digits, 4-cycle stability window.
module tb_segment_scan_decoder;
    localparam int ND = 6;
    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   errors   = 0;
    int   fv_count = 0;
    int   base     = 0;

    segment_scan_if #(.NUM_DIGITS(ND)) bif ();

    segment_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bif.frame_valid === 1'b1) fv_count++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: pat = 7'b1000000;
            1: pat = 7'b1111001;
            2: pat = 7'b0100100;
            3: pat = 7'b0110000;
            4: pat = 7'b0011001;
            5: pat = 7'b0010010;
            6: pat = 7'b0000010;
            7: pat = 7'b1111000;
            8: pat = 7'b0000000;
            9: pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [ND-1:0] an, input logic [6:0] seg, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bif.an_in  = an;
            bif.seg_in = seg;
        end
    endtask

    task automatic slot(input int pos, input logic [6:0] seg, input int n);
        logic [ND-1:0] an;
        an      = '1;
        an[pos] = 1'b0;
        drive(an, seg, n);
    endtask

    task automatic blank(input int n);
        drive('1, 7'b1111111, n);
    endtask

    // Scans the selected positions in ascending order, each for SC cycles followed by one blank cycle.
    task automatic scan(input logic [23:0] digs, input logic [ND-1:0] which);
        for (int i = 0; i < ND; i++) begin
            if (which[i]) begin
                slot(i, pat(int'(digs[4*i +: 4])), SC);
                blank(1);
            end
        end
    endtask

    initial begin
        bif.an_in  = '1;
        bif.seg_in = 7'b1111111;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_digits", 32'(bif.digits_out), 32'h0);
        chk("reset_err", 32'(bif.digit_err), 32'h0);
        chk("reset_fv", 32'(bif.frame_valid), 32'h0);
        rst = 1'b0;
        blank(2);

        // Clean frame with exact latency on the last slot
        slot(0, pat(5), SC); blank(1);
        slot(1, pat(4), SC); blank(1);
        slot(2, pat(3), SC); blank(1);
        slot(3, pat(2), SC); blank(1);
        slot(4, pat(1), SC); blank(1);
        slot(5, pat(0), SC);
        @(negedge clk);
        chk("clean_fv_early", 32'(bif.frame_valid), 32'h0);
        bif.an_in  = '1;
        bif.seg_in = 7'b1111111;
        @(negedge clk);
        chk("clean_fv_pulse", 32'(bif.frame_valid), 32'h1);
        chk("clean_digits", 32'(bif.digits_out), 32'h012345);
        chk("clean_err", 32'(bif.digit_err), 32'h0);
        blank(2);
        chk("clean_fv_count", 32'(fv_count), 32'd1);
        chk("clean_fv_low", 32'(bif.frame_valid), 32'h0);

        // Reset in the middle of a dwell after three positions were seen
        base = fv_count;
        scan(24'h456789, 6'b000111);
        slot(3, pat(6), 2);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_digits", 32'(bif.digits_out), 32'h0);
        chk("midrst_err", 32'(bif.digit_err), 32'h0);
        chk("midrst_fv", 32'(bif.frame_valid), 32'h0);
        rst = 1'b0;
        blank(1);
        scan(24'h456789, 6'b111000);
        blank(2);
        chk("midrst_partial_nofv", 32'(fv_count - base), 32'd0);
        chk("midrst_partial_digits", 32'(bif.digits_out), 32'h0);
        scan(24'h456789, 6'b000111);
        blank(3);
        chk("midrst_full_fv", 32'(fv_count - base), 32'd1);
        chk("midrst_full_digits", 32'(bif.digits_out), 32'h456789);

        // Short dwell on position 2 is ignored
        base = fv_count;
        scan(24'h654321, 6'b111011);
        slot(2, pat(3), SC - 1);
        blank(3);
        chk("short_nofv", 32'(fv_count - base), 32'd0);
        chk("short_digits_kept", 32'(bif.digits_out), 32'h456789);
        slot(2, pat(3), SC);
        blank(3);
        chk("short_fv", 32'(fv_count - base), 32'd1);
        chk("short_digits", 32'(bif.digits_out), 32'h654321);

        // Blank pattern on position 3 is flagged
        base = fv_count;
        scan(24'h88F888, 6'b111111);
        blank(2);
        chk("inval_fv", 32'(fv_count - base), 32'd1);
        chk("inval_digits", 32'(bif.digits_out), 32'h88F888);
        chk("inval_nibble", 32'(bif.digits_out[15:12]), 32'hF);
        chk("inval_err", 32'(bif.digit_err), 32'b001000);

        // Glitch inside a dwell, then a long hold on the last position
        base = fv_count;
        slot(0, pat(2), 2);
        slot(0, pat(3), 1);
        slot(0, pat(2), 7);
        blank(1);
        scan(24'h900002, 6'b011110);
        slot(5, pat(9), 20);
        blank(3);
        chk("glitch_fv", 32'(fv_count - base), 32'd1);
        chk("glitch_digits", 32'(bif.digits_out), 32'h900002);
        chk("glitch_err", 32'(bif.digit_err), 32'h0);

        // Two-low anode values are not slots; the long hold must not have left position 5 seen
        base = fv_count;
        scan(24'h111111, 6'b011111);
        drive(6'b111100, pat(8), 8);
        blank(3);
        chk("twolow_nofv", 32'(fv_count - base), 32'd0);
        chk("twolow_digits_kept", 32'(bif.digits_out), 32'h900002);
        scan(24'h111111, 6'b100000);
        blank(3);
        chk("twolow_fv", 32'(fv_count - base), 32'd1);
        chk("twolow_digits", 32'(bif.digits_out), 32'h111111);

        // Position 0 overwritten before the frame completes
        base = fv_count;
        slot(0, pat(7), SC); blank(1);
        scan(24'h333333, 6'b011110);
        slot(0, pat(8), SC); blank(1);
        blank(2);
        chk("ovw_nofv_yet", 32'(fv_count - base), 32'd0);
        scan(24'h333333, 6'b100000);
        blank(3);
        chk("ovw_fv", 32'(fv_count - base), 32'd1);
        chk("ovw_digits", 32'(bif.digits_out), 32'h333338);
        chk("ovw_err", 32'(bif.digit_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/segment_scan_decoder.md
# segment_scan_decoder

Recovers BCD digits from a multiplexed, active-low seven-segment display bus, such as the segment/anode lines driven toward the display by the clock's digit encoder and scan multiplexer. It samples the segment and anode lines, waits for each scan slot to be stable, and inverse-maps each segment pattern to a 4-bit digit. Once every digit position has been captured, it presents a coherent frame (e.g. HH:MM:SS for 6 digits). It serves as a self-checking monitor and as a loopback source for the time-readback path.

## Interface
- NUM_DIGITS, 6, number of scanned digit positions (2..8)
- STABLE_CYCLES, 4, consecutive identical samples required to accept a slot (2..255)
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- seg_in  in  7  segment lines, active-low (0 = lit); bit 0 = a … bit 6 = g
- an_in  in  NUM_DIGITS  digit enables, active-low; exactly one low selects a slot; bit 0 = least-significant digit
- digits_out  out  4*NUM_DIGITS  last complete frame; digit i occupies bits [4i+3:4i]
- digit_err  out  NUM_DIGITS  per-digit flag: the pattern in the last frame was not a decimal digit
- frame_valid  out  1  one-cycle pulse when digits_out/digit_err update

## Operation
- Inverse map (seg_in → digit): 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9. Every other pattern, including blank 1111111, maps to 4'hF and is flagged as an error.
- Slot definition: an_in has exactly one 0 bit. The index of that bit is the digit position. All-ones (blanking) and multi-low values are not slots.
- FSM states:
  - IDLE: no valid slot, or the {an_in, seg_in} pair changed. Stability counter = 1 on a valid slot sample, else 0. → SETTLE on a valid slot.
  - SETTLE: the counter increments while the pair equals the previous sample. Any change → counter restarts at 1 (new valid slot) or → IDLE (non-slot). When the count reaches STABLE_CYCLES, accept the slot and → HOLD.
  - HOLD: the slot is already accepted. Remain here while the pair is unchanged; no re-accept. On change, act as IDLE does with the new sample.
- Accept: shadow[idx] ← mapped digit; shadow_err[idx] ← invalid; seen[idx] ← 1. Re-accepting an already-seen position overwrites the shadow only.
- Frame completion: when seen (including this acceptance) is all ones:
  - On the next edge, digits_out ← shadow and digit_err ← shadow_err, each including the just-accepted digit.
  - frame_valid = 1 for that one cycle.
  - seen clears.
- Blanking between slots does not clear seen. Partial frames persist until completed or reset.
- Counter saturates at STABLE_CYCLES; there is no wrap.

## Timing
- Reset values: digits_out = 0, digit_err = 0, frame_valid = 0; shadow, seen and counter = 0; state = IDLE.
- Acceptance edge: if the same valid pair is sampled at edges e … e+STABLE_CYCLES−1, the shadow is written at edge e+STABLE_CYCLES−1.
- Frame latency: frame_valid and the new digits_out appear after edge e+STABLE_CYCLES, i.e. one cycle after the final acceptance.
- Minimum dwell: a slot must be held for at least STABLE_CYCLES cycles to register. A shorter dwell is ignored entirely.
- frame_valid never asserts on two consecutive cycles. The minimum spacing is NUM_DIGITS·STABLE_CYCLES cycles.
- Reset mid-dwell or mid-frame: all partial state is discarded. Outputs return to reset values on the edge where rst = 1 is sampled. rst has priority over every acceptance.
- Outputs are registered. digits_out and digit_err are stable between frame_valid pulses.

## Test plan
- Reset behaviour: assert rst mid-SETTLE with seen = 3'b111 (of 6) → next cycle all outputs are 0. A full following frame is then required before frame_valid.
- Clean frame: scan positions 0..5 with patterns 5,4,3,2,1,0 (0010010, 0011001, 0110000, 0100100, 1111001, 1000000), each held 4 cycles with 1 blank cycle between → one frame_valid pulse; digits_out = 24'h012345; digit_err = 0.
- Short dwell: hold position 2 for 3 cycles (STABLE_CYCLES = 4) → no accept, no frame. Repeating it for 4 cycles completes the frame.
- Invalid pattern: position 3 = 1111111 → digits_out[15:12] = 4'hF; digit_err = 6'b001000.
- Glitch and hold: seg_in changes for 1 cycle inside a 10-cycle dwell → counter restarts, accept occurs once; holding 20 cycles also yields only one accept. Two-low an_in (6'b111100) → never accepted.
- Overwrite: position 0 is accepted as 7, then as 8 before the frame completes → frame shows digit 0 = 8, with exactly one frame_valid pulse.
